dm_port_arbiter: RTL and testbench

//  Shares the single-port data memory between two requesters: port 0 (CPU load/store) and port 1 (DMA/debug).

---
 rtl/dm_port_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_dm_port_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory.
// Serialises CPU and DMA/debug accesses, rejects illegal size/alignment and gives every load a uniform latency.
module dm_port_arbiter #(
    parameter int ADDR_W     = 8,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        req0_i,
    input  logic        req1_i,
    input  logic        we0_i,
    input  logic        we1_i,
    input  logic [2:0]  size0_i,
    input  logic [2:0]  size1_i,
    input  logic [31:0] a0_i,
    input  logic [31:0] a1_i,
    input  logic [31:0] wd0_i,
    input  logic [31:0] wd1_i,
    output logic        gnt0_o,
    output logic        gnt1_o,
    output logic        rvalid0_o,
    output logic        rvalid1_o,
    output logic [31:0] rd0_o,
    output logic [31:0] rd1_o,
    output logic        err0_o,
    output logic        err1_o,
    output logic        dm_we_o,
    output logic [2:0]  dm_size_o,
    output logic [31:0] dm_a_o,
    output logic [31:0] dm_wd_o,
    input  logic [31:0] dm_rd_i
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_CAPTURE,
        S_RESP
    } state_t;

    localparam logic [2:0] SIZE_W = 3'd2;

    state_t      state_q, state_d;
    logic        prio_q, prio_d;
    logic        win_q, win_d;
    logic        we_q, we_d;
    logic        legal_q, legal_d;
    logic [1:0]  gnt_q, gnt_d;
    logic [1:0]  rvalid_q, rvalid_d;
    logic [1:0]  err_q, err_d;
    logic [31:0] rd_q [2];
    logic [31:0] rd_d [2];
    logic        dm_we_q, dm_we_d;
    logic [2:0]  dm_size_q, dm_size_d;
    logic [31:0] dm_a_q, dm_a_d;
    logic [31:0] dm_wd_q, dm_wd_d;

    logic        win_sel;
    logic        sel_we;
    logic [2:0]  sel_size;
    logic [31:0] sel_a;
    logic [31:0] sel_wd;
    logic        sel_legal;

    // Illegal: reserved size codes, misaligned word, halfword straddling a word, address beyond the DM.
    function automatic logic req_legal(input logic [2:0] size, input logic [31:0] a);
        logic ok;
        ok = 1'b1;
        if (size == 3'd3 || size == 3'd6 || size == 3'd7)
            ok = 1'b0;
        if (size == 3'd2 && a[1:0] != 2'b00)
            ok = 1'b0;
        if ((size == 3'd1 || size == 3'd5) && a[1:0] == 2'b11)
            ok = 1'b0;
        if (|a[31:ADDR_W])
            ok = 1'b0;
        return ok;
    endfunction

    always_comb begin
        if (req0_i && req1_i)
            win_sel = FIXED_PRIO ? 1'b0 : prio_q;
        else
            win_sel = req1_i;
        sel_we    = win_sel ? we1_i   : we0_i;
        sel_size  = win_sel ? size1_i : size0_i;
        sel_a     = win_sel ? a1_i    : a0_i;
        sel_wd    = win_sel ? wd1_i   : wd0_i;
        sel_legal = req_legal(sel_size, sel_a);
    end

    // Outputs are registered, so each state's outputs are produced on the edge that enters it.
    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        win_d     = win_q;
        we_d      = we_q;
        legal_d   = legal_q;
        gnt_d     = 2'b00;
        rvalid_d  = 2'b00;
        err_d     = 2'b00;
        rd_d      = rd_q;
        dm_we_d   = 1'b0;
        dm_size_d = dm_size_q;
        dm_a_d    = dm_a_q;
        dm_wd_d   = dm_wd_q;

        case (state_q)
            S_IDLE: begin
                if (req0_i || req1_i) begin
                    win_d          = win_sel;
                    we_d           = sel_we;
                    legal_d        = sel_legal;
                    prio_d         = ~win_sel;
                    gnt_d[win_sel] = 1'b1;
                    dm_we_d        = sel_legal & sel_we;
                    if (sel_legal) begin
                        dm_size_d = sel_size;
                        dm_a_d    = sel_a;
                        dm_wd_d   = sel_wd;
                    end
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (!legal_q || we_q) begin
                    rvalid_d[win_q] = 1'b1;
                    err_d[win_q]    = ~legal_q;
                    rd_d[win_q]     = '0;
                    state_d         = S_RESP;
                end else begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                rvalid_d[win_q] = 1'b1;
                rd_d[win_q]     = dm_rd_i;
                state_d         = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            prio_q    <= 1'b0;
            win_q     <= 1'b0;
            we_q      <= 1'b0;
            legal_q   <= 1'b0;
            gnt_q     <= 2'b00;
            rvalid_q  <= 2'b00;
            err_q     <= 2'b00;
            rd_q[0]   <= '0;
            rd_q[1]   <= '0;
            dm_we_q   <= 1'b0;
            dm_size_q <= SIZE_W;
            dm_a_q    <= '0;
            dm_wd_q   <= '0;
        end else begin
            state_q   <= state_d;
            prio_q    <= prio_d;
            win_q     <= win_d;
            we_q      <= we_d;
            legal_q   <= legal_d;
            gnt_q     <= gnt_d;
            rvalid_q  <= rvalid_d;
            err_q     <= err_d;
            rd_q[0]   <= rd_d[0];
            rd_q[1]   <= rd_d[1];
            dm_we_q   <= dm_we_d;
            dm_size_q <= dm_size_d;
            dm_a_q    <= dm_a_d;
            dm_wd_q   <= dm_wd_d;
        end
    end

    assign gnt0_o    = gnt_q[0];
    assign gnt1_o    = gnt_q[1];
    assign rvalid0_o = rvalid_q[0];
    assign rvalid1_o = rvalid_q[1];
    assign err0_o    = err_q[0];
    assign err1_o    = err_q[1];
    assign rd0_o     = rd_q[0];
    assign rd1_o     = rd_q[1];
    assign dm_we_o   = dm_we_q;
    assign dm_size_o = dm_size_q;
    assign dm_a_o    = dm_a_q;
    assign dm_wd_o   = dm_wd_q;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter with a byte-addressed DM model
// (word loads combinational, sub-word loads registered) plus a fixed-priority instance.
module tb_dm_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1, we0, we1;
    logic [2:0]  size0, size1;
    logic [31:0] a0, a1, wd0, wd1;
    logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
    logic [31:0] rd0, rd1;
    logic        dm_we;
    logic [2:0]  dm_size;
    logic [31:0] dm_a, dm_wd, dm_rd;

    logic        fp_gnt0, fp_gnt1, fp_rvalid0, fp_rvalid1, fp_err0, fp_err1, fp_dm_we;
    logic [31:0] fp_rd0, fp_rd1, fp_dm_a, fp_dm_wd;
    logic [2:0]  fp_dm_size;
    logic [31:0] fp_dm_rd = 32'h0;

    int n_checks = 0;
    int n_fail   = 0;
    int we_cnt   = 0;

    always #5 clk = ~clk;

    dm_port_arbiter #(.ADDR_W(8), .FIXED_PRIO(1'b0)) u_dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
        .size0_i(size0), .size1_i(size1), .a0_i(a0), .a1_i(a1),
        .wd0_i(wd0), .wd1_i(wd1),
        .gnt0_o(gnt0), .gnt1_o(gnt1), .rvalid0_o(rvalid0), .rvalid1_o(rvalid1),
        .rd0_o(rd0), .rd1_o(rd1), .err0_o(err0), .err1_o(err1),
        .dm_we_o(dm_we), .dm_size_o(dm_size), .dm_a_o(dm_a), .dm_wd_o(dm_wd),
        .dm_rd_i(dm_rd)
    );

    dm_port_arbiter #(.ADDR_W(8), .FIXED_PRIO(1'b1)) u_fp (
        .clk_i(clk), .rst_n_i(rst_n),
        .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
        .size0_i(size0), .size1_i(size1), .a0_i(a0), .a1_i(a1),
        .wd0_i(wd0), .wd1_i(wd1),
        .gnt0_o(fp_gnt0), .gnt1_o(fp_gnt1), .rvalid0_o(fp_rvalid0), .rvalid1_o(fp_rvalid1),
        .rd0_o(fp_rd0), .rd1_o(fp_rd1), .err0_o(fp_err0), .err1_o(fp_err1),
        .dm_we_o(fp_dm_we), .dm_size_o(fp_dm_size), .dm_a_o(fp_dm_a), .dm_wd_o(fp_dm_wd),
        .dm_rd_i(fp_dm_rd)
    );

    // DM model
    logic [7:0]  mem [256];
    logic [31:0] sub_rd;
    logic [7:0]  ma;

    assign ma = dm_a[7:0];

    function automatic logic [31:0] sub_load(input logic [2:0] sz, input logic [7:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        b = mem[a];
        h = {mem[8'(a + 8'd1)], mem[a]};
        case (sz)
            3'd0:    return {{24{b[7]}}, b};
            3'd4:    return {24'h0, b};
            3'd1:    return {{16{h[15]}}, h};
            3'd5:    return {16'h0, h};
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (dm_we) begin
            case (dm_size)
                3'd0: mem[ma] <= dm_wd[7:0];
                3'd1: begin
                    mem[ma]              <= dm_wd[7:0];
                    mem[8'(ma + 8'd1)]   <= dm_wd[15:8];
                end
                default: begin
                    mem[ma]              <= dm_wd[7:0];
                    mem[8'(ma + 8'd1)]   <= dm_wd[15:8];
                    mem[8'(ma + 8'd2)]   <= dm_wd[23:16];
                    mem[8'(ma + 8'd3)]   <= dm_wd[31:24];
                end
            endcase
        end
        sub_rd <= sub_load(dm_size, ma);
    end

    assign dm_rd = (dm_size == 3'd2) ? {mem[8'(ma + 8'd3)], mem[8'(ma + 8'd2)],
                                        mem[8'(ma + 8'd1)], mem[ma]} : sub_rd;

    always @(negedge clk) if (dm_we) we_cnt++;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_port(input int p, input logic rq, input logic we, input logic [2:0] sz,
                              input logic [31:0] a, input logic [31:0] wd);
        if (p == 0) begin
            req0 = rq; we0 = we; size0 = sz; a0 = a; wd0 = wd;
        end else begin
            req1 = rq; we1 = we; size1 = sz; a1 = a; wd1 = wd;
        end
    endtask

    // Called at a negedge while the DUT is in IDLE; returns at a negedge in IDLE.
    task automatic xact(input string tag, input int p, input logic we, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic exp_err, input logic [31:0] exp_rd);
        int lat;
        int we0_cnt;
        bit got;
        logic o_err;
        logic [31:0] o_rd;
        we0_cnt = we_cnt;
        drive_port(p, 1'b1, we, sz, a, wd);
        @(negedge clk);
        check_eq({tag, "_gnt"}, (p == 0) ? gnt0 : gnt1, 1'b1);
        check_eq({tag, "_gnt_other"}, (p == 0) ? gnt1 : gnt0, 1'b0);
        drive_port(p, 1'b0, 1'b0, 3'd2, 32'h0, 32'h0);
        lat = 1;
        got = 1'b0;
        o_err = 1'b0;
        o_rd = 32'h0;
        for (int i = 0; i < 6 && !got; i++) begin
            @(negedge clk);
            lat++;
            if ((p == 0) ? rvalid0 : rvalid1) begin
                got   = 1'b1;
                o_err = (p == 0) ? err0 : err1;
                o_rd  = (p == 0) ? rd0 : rd1;
            end
        end
        if (!got) lat = 99;
        check_eq({tag, "_lat"}, lat, (we || exp_err) ? 2 : 3);
        check_eq({tag, "_err"}, o_err, exp_err);
        check_eq({tag, "_rd"}, o_rd, exp_rd);
        check_eq({tag, "_dmwe"}, we_cnt - we0_cnt, (we && !exp_err) ? 1 : 0);
        $display("xact %s port%0d we=%0d size=%0d a=%h wd=%h rd=%h err=%0d lat=%0d",
                 tag, p, we, sz, a, wd, o_rd, o_err, lat);
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ngr;
        int port;
        bit seen;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        rst_n = 1'b0;
        drive_port(0, 1'b0, 1'b0, 3'd2, 32'h0, 32'h0);
        drive_port(1, 1'b0, 1'b0, 3'd2, 32'h0, 32'h0);
        repeat (3) @(negedge clk);

        // Reset state
        check_eq("rst_gnt", {30'h0, gnt1, gnt0}, 32'h0);
        check_eq("rst_rvalid", {30'h0, rvalid1, rvalid0}, 32'h0);
        check_eq("rst_err", {30'h0, err1, err0}, 32'h0);
        check_eq("rst_rd0", rd0, 32'h0);
        check_eq("rst_rd1", rd1, 32'h0);
        check_eq("rst_dm_we", dm_we, 1'b0);
        check_eq("rst_dm_size", dm_size, 3'd2);
        check_eq("rst_dm_a", dm_a, 32'h0);
        check_eq("rst_dm_wd", dm_wd, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Store then word load
        xact("sw10", 0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
        xact("lw10", 0, 1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);

        // Sub-word loads
        xact("sw20", 1, 1'b1, 3'd2, 32'h20, 32'h80FF7F01, 1'b0, 32'h0);
        xact("lb21", 0, 1'b0, 3'd0, 32'h21, 32'h0, 1'b0, 32'h0000007F);
        xact("lb23", 1, 1'b0, 3'd0, 32'h23, 32'h0, 1'b0, 32'hFFFFFF80);
        xact("lbu22", 0, 1'b0, 3'd4, 32'h22, 32'h0, 1'b0, 32'h000000FF);
        xact("lh22", 1, 1'b0, 3'd1, 32'h22, 32'h0, 1'b0, 32'hFFFF80FF);
        xact("lhu22", 0, 1'b0, 3'd5, 32'h22, 32'h0, 1'b0, 32'h000080FF);
        xact("sb24", 0, 1'b1, 3'd0, 32'h24, 32'h000000A5, 1'b0, 32'h0);
        xact("lw24", 1, 1'b0, 3'd2, 32'h24, 32'h0, 1'b0, 32'h000000A5);

        // Illegal requests
        xact("sw12_bad", 0, 1'b1, 3'd2, 32'h12, 32'h12345678, 1'b1, 32'h0);
        xact("lh13_bad", 1, 1'b0, 3'd1, 32'h13, 32'h0, 1'b1, 32'h0);
        xact("sz3_bad", 0, 1'b1, 3'd3, 32'h10, 32'h55555555, 1'b1, 32'h0);
        xact("sw100_bad", 1, 1'b1, 3'd2, 32'h100, 32'hCAFEF00D, 1'b1, 32'h0);
        xact("lw10_chk", 0, 1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);
        xact("lw00_chk", 1, 1'b0, 3'd2, 32'h00, 32'h0, 1'b0, 32'h0);

        // Round-robin with both requests held; fixed-priority instance in parallel
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive_port(0, 1'b1, 1'b1, 3'd2, 32'h40, 32'h11110000);
        drive_port(1, 1'b1, 1'b1, 3'd2, 32'h44, 32'h22220000);
        ngr = 0;
        for (int cyc = 0; cyc < 40 && ngr < 6; cyc++) begin
            @(negedge clk);
            if (gnt0 || gnt1) begin
                port = gnt1 ? 1 : 0;
                check_eq("rr_order", port, ngr % 2);
                check_eq("rr_one_gnt", gnt0 & gnt1, 1'b0);
                check_eq("fp_gnt0", {fp_gnt1, fp_gnt0}, 2'b01);
                $display("xact rr grant%0d port%0d fp_gnt0=%0d", ngr, port, fp_gnt0);
                ngr++;
            end
        end
        check_eq("rr_count", ngr, 6);
        drive_port(0, 1'b0, 1'b0, 3'd2, 32'h0, 32'h0);
        drive_port(1, 1'b0, 1'b0, 3'd2, 32'h0, 32'h0);
        repeat (4) @(negedge clk);
        xact("lw40", 0, 1'b0, 3'd2, 32'h40, 32'h0, 1'b0, 32'h11110000);
        xact("lw44", 1, 1'b0, 3'd2, 32'h44, 32'h0, 1'b0, 32'h22220000);

        // Reset during CAPTURE of a port1 load
        drive_port(1, 1'b1, 1'b0, 3'd2, 32'h10, 32'h0);
        @(negedge clk);
        check_eq("abort_gnt1", gnt1, 1'b1);
        drive_port(1, 1'b0, 1'b0, 3'd2, 32'h0, 32'h0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("abort_rvalid1", rvalid1, 1'b0);
        check_eq("abort_gnt", {30'h0, gnt1, gnt0}, 32'h0);
        check_eq("abort_err1", err1, 1'b0);
        check_eq("abort_rd0", rd0, 32'h0);
        check_eq("abort_rd1", rd1, 32'h0);
        check_eq("abort_dm_a", dm_a, 32'h0);
        check_eq("abort_dm_size", dm_size, 3'd2);
        check_eq("abort_dm_we", dm_we, 1'b0);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (rvalid1 || rvalid0) seen = 1'b1;
        end
        check_eq("abort_no_rvalid", seen, 1'b0);
        xact("post_rst_lw", 0, 1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
